controle_treino: RTL and testbench

CONTROLE_TREINO -- requirements
Module: controle_treino

---
 rtl/treino_pkg.sv | 20 ++
 rtl/conta_erros.sv | 27 ++
 rtl/controle_treino.sv | 182 ++++++++++++++++++
 tb/tb_controle_treino.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/treino_pkg.sv
// Shared definitions for the perceptron training controller: word width,
// half-precision constants and the controller state encoding.
package treino_pkg;

  localparam int TAM          = 16;
  localparam int NUM_AMOSTRAS = 4;

  localparam logic [15:0] FP_ONE  = 16'h3C00;
  localparam logic [15:0] FP_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } estado_e;

endpackage

// File: rtl/conta_erros.sv
// Classifies each half-precision sample as logic one/zero and counts how many
// epoch outputs disagree with the desired outputs.
module conta_erros
  import treino_pkg::*;
#(
  parameter int TAM = treino_pkg::TAM
) (
  input  logic [NUM_AMOSTRAS*TAM-1:0] d_i,
  input  logic [NUM_AMOSTRAS*TAM-1:0] result_i,
  output logic [2:0]                  err_cnt_o
);

  // Strictly positive words are one; +0, -0 and every negative word are zero.
  function automatic logic eh_um(input logic [TAM-1:0] w);
    return (w[TAM-1] == 1'b0) && (w[TAM-2:0] != '0);
  endfunction

  always_comb begin
    err_cnt_o = '0;
    for (int i = 0; i < NUM_AMOSTRAS; i++) begin
      if (eh_um(result_i[i*TAM +: TAM]) != eh_um(d_i[i*TAM +: TAM])) begin
        err_cnt_o = err_cnt_o + 3'd1;
      end
    end
  end

endmodule

// File: rtl/controle_treino.sv
// Training-loop controller: launches epochs, checks their error count and
// updates weights until convergence or MAX_EP. Optional feature: define
// CONTROLE_TREINO_TIMEOUT_EN to abort when the epoch stage stops answering.
module controle_treino
  import treino_pkg::*;
#(
  parameter int TAM        = treino_pkg::TAM,
  parameter int MAX_EP     = 64,
  parameter int EP_TIMEOUT = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_AMOSTRAS*TAM-1:0] d,
  input  logic [TAM-1:0]              w_init0,
  input  logic [TAM-1:0]              w_init1,
  input  logic [TAM-1:0]              w_init2,
  output logic [TAM-1:0]              ep_w0,
  output logic [TAM-1:0]              ep_w1,
  output logic [TAM-1:0]              ep_w2,
  output logic                        ep_go,
  input  logic                        ep_done,
  input  logic [NUM_AMOSTRAS*TAM-1:0] ep_result,
  input  logic [TAM-1:0]              ep_wn0,
  input  logic [TAM-1:0]              ep_wn1,
  input  logic [TAM-1:0]              ep_wn2,
  output logic                        busy,
  output logic                        done,
  output logic                        converged,
  output logic                        timeout,
  output logic [7:0]                  epoch_cnt,
  output logic [2:0]                  err_cnt
);

  if (MAX_EP < 1 || MAX_EP > 255 || EP_TIMEOUT < 1) begin : g_param_invalido
    $error("controle_treino: MAX_EP must be 1..255 and EP_TIMEOUT at least 1");
  end

  localparam logic [7:0] MaxEp = 8'(MAX_EP);

  estado_e        state_q;
  logic [TAM-1:0] w0_q, w1_q, w2_q;
  logic [TAM-1:0] wn0_q, wn1_q, wn2_q;
  logic           ep_go_q, busy_q, done_q, conv_q;
  logic [7:0]     epoch_q;
  logic [2:0]     err_q;
  logic [2:0]     err_d;
  logic [7:0]     epoch_d;

  conta_erros #(.TAM(TAM)) u_conta_erros (
    .d_i      (d),
    .result_i (ep_result),
    .err_cnt_o(err_d)
  );

  assign epoch_d = (epoch_q == MaxEp) ? epoch_q : epoch_q + 8'd1;

`ifdef CONTROLE_TREINO_TIMEOUT_EN
  localparam int WaitW = $clog2(EP_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(EP_TIMEOUT - 1);

  logic [WaitW-1:0] wait_q;
  logic             tmo_q;
`endif

  // Outputs are registered alongside each transition so they track state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      wn0_q   <= '0;
      wn1_q   <= '0;
      wn2_q   <= '0;
      ep_go_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      epoch_q <= '0;
      err_q   <= '0;
`ifdef CONTROLE_TREINO_TIMEOUT_EN
      wait_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          w0_q    <= w_init0;
          w1_q    <= w_init1;
          w2_q    <= w_init2;
          epoch_q <= '0;
          err_q   <= '0;
          conv_q  <= 1'b0;
`ifdef CONTROLE_TREINO_TIMEOUT_EN
          tmo_q   <= 1'b0;
`endif
          ep_go_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          ep_go_q <= 1'b0;
`ifdef CONTROLE_TREINO_TIMEOUT_EN
          wait_q  <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (ep_done) begin
            err_q   <= err_d;
            wn0_q   <= ep_wn0;
            wn1_q   <= ep_wn1;
            wn2_q   <= ep_wn2;
            state_q <= CHECK;
          end
`ifdef CONTROLE_TREINO_TIMEOUT_EN
          else if (wait_q == WaitLast) begin
            tmo_q   <= 1'b1;
            conv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        CHECK: begin
          epoch_q <= epoch_d;
          if (err_q == 3'd0) begin
            conv_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            w0_q <= wn0_q;
            w1_q <= wn1_q;
            w2_q <= wn2_q;
            if (epoch_d == MaxEp) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ep_go_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        default: begin
          ep_go_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ep_w0     = w0_q;
  assign ep_w1     = w1_q;
  assign ep_w2     = w2_q;
  assign ep_go     = ep_go_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt   = err_q;

`ifdef CONTROLE_TREINO_TIMEOUT_EN
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_controle_treino.sv
// Scoreboard bench for controle_treino with a behavioural epoch-stage stub;
// expectations for the timeout scenario follow CONTROLE_TREINO_TIMEOUT_EN.
module tb_controle_treino;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] d;
  logic [15:0] w_init0, w_init1, w_init2;
  logic [15:0] ep_w0, ep_w1, ep_w2;
  logic        ep_go;
  logic        ep_done;
  logic [63:0] ep_result;
  logic [15:0] ep_wn0, ep_wn1, ep_wn2;
  logic        busy, done, converged, timeout;
  logic [7:0]  epoch_cnt;
  logic [2:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  ep;
    logic [2:0]  err;
    logic        conv;
    logic        tmo;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    int          gos;
  } exp_t;

  exp_t sb_q[$];

  // Epoch-stage stub: answers each ep_go one cycle later with a per-epoch result.
  logic [63:0] stub_res [0:3];
  logic [15:0] stub_wn0, stub_wn1, stub_wn2;
  bit          stub_silent;
  int          go_count;

  always #5 clk = ~clk;

  controle_treino #(.TAM(16), .MAX_EP(4), .EP_TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .start(start), .d(d),
    .w_init0(w_init0), .w_init1(w_init1), .w_init2(w_init2),
    .ep_w0(ep_w0), .ep_w1(ep_w1), .ep_w2(ep_w2), .ep_go(ep_go),
    .ep_done(ep_done), .ep_result(ep_result),
    .ep_wn0(ep_wn0), .ep_wn1(ep_wn1), .ep_wn2(ep_wn2),
    .busy(busy), .done(done), .converged(converged), .timeout(timeout),
    .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
  );

  initial begin
    int idx;
    go_count = 0;
    forever begin
      @(posedge clk);
      if (ep_go === 1'b1) begin
        go_count++;
        idx = (go_count > 4) ? 3 : go_count - 1;
        if (!stub_silent) begin
          @(negedge clk);
          ep_done   = 1'b1;
          ep_result = stub_res[idx];
          ep_wn0    = stub_wn0;
          ep_wn1    = stub_wn1;
          ep_wn2    = stub_wn2;
          @(negedge clk);
          ep_done   = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic set_stub(input logic [63:0] r0, input logic [63:0] r1, input logic [63:0] r2,
                          input logic [63:0] r3, input logic [15:0] wn);
    stub_res[0] = r0; stub_res[1] = r1; stub_res[2] = r2; stub_res[3] = r3;
    stub_wn0 = wn; stub_wn1 = wn; stub_wn2 = wn;
    stub_silent = 1'b0;
    go_count = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ep_go !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ep_go: got %b want 0", ep_go); end
    n_cmp++; if ({done, converged, timeout, epoch_cnt, err_cnt} !== 14'd0) begin
      n_err++; $display("[TB] FAIL reset_flags: got %b want 0", {done, converged, timeout, epoch_cnt, err_cnt});
    end
    n_cmp++; if ({ep_w0, ep_w1, ep_w2} !== 48'd0) begin
      n_err++; $display("[TB] FAIL reset_weights: got %h want 0", {ep_w0, ep_w1, ep_w2});
    end
    start = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL idle_hold: busy got %b want 0", busy); end
  endtask

  task automatic test_converge_first();
    exp_t e; bit ok;
    d = 64'h3C00_3C00_3C00_0000;
    w_init0 = 16'h3C00; w_init1 = 16'h4000; w_init2 = 16'hBC00;
    set_stub(64'h3C00_3C00_3C00_0000, 64'h0, 64'h0, 64'h0, 16'h1234);
    sb_q.push_back('{ep:8'd1, err:3'd0, conv:1'b1, tmo:1'b0, w0:16'h3C00, w1:16'h4000, w2:16'hBC00, gos:1});
    pulse_start();
    wait_done(200, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL first_done: got %b want 1", done); end
    n_cmp++; if (epoch_cnt !== e.ep) begin n_err++; $display("[TB] FAIL first_epoch: got %0d want %0d", epoch_cnt, e.ep); end
    n_cmp++; if (err_cnt !== e.err) begin n_err++; $display("[TB] FAIL first_err: got %0d want %0d", err_cnt, e.err); end
    n_cmp++; if (converged !== e.conv) begin n_err++; $display("[TB] FAIL first_conv: got %b want %b", converged, e.conv); end
    n_cmp++; if ({ep_w0, ep_w1, ep_w2} !== {e.w0, e.w1, e.w2}) begin
      n_err++; $display("[TB] FAIL first_weights: got %h want %h", {ep_w0, ep_w1, ep_w2}, {e.w0, e.w1, e.w2});
    end
    n_cmp++; if (go_count !== e.gos) begin n_err++; $display("[TB] FAIL first_gos: got %0d want %0d", go_count, e.gos); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL first_busy: got %b want 0", busy); end
  endtask

  task automatic test_neg_zero();
    exp_t e; bit ok;
    w_init0 = 16'h0400; w_init1 = 16'h0800; w_init2 = 16'h0C00;
    set_stub(64'h4000_3555_7BFF_8000, 64'h0, 64'h0, 64'h0, 16'h5555);
    sb_q.push_back('{ep:8'd1, err:3'd0, conv:1'b1, tmo:1'b0, w0:16'h0400, w1:16'h0800, w2:16'h0C00, gos:1});
    pulse_start();
    wait_done(200, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL negz_done: got %b want 1", done); end
    n_cmp++; if (err_cnt !== e.err) begin n_err++; $display("[TB] FAIL negz_err: got %0d want %0d", err_cnt, e.err); end
    n_cmp++; if (converged !== e.conv) begin n_err++; $display("[TB] FAIL negz_conv: got %b want %b", converged, e.conv); end
    n_cmp++; if ({ep_w0, ep_w1, ep_w2} !== {e.w0, e.w1, e.w2}) begin
      n_err++; $display("[TB] FAIL negz_weights: got %h want %h", {ep_w0, ep_w1, ep_w2}, {e.w0, e.w1, e.w2});
    end
  endtask

  task automatic test_converge_third(input bit poke_start);
    exp_t e; bit ok;
    w_init0 = 16'h3C00; w_init1 = 16'hC400; w_init2 = 16'h4200;
    set_stub(64'h3C00_3C00_BC00_3C00, 64'h3C00_3C00_BC00_3C00,
             64'h3C00_3C00_3C00_0000, 64'h3C00_3C00_3C00_0000, 16'h3800);
    sb_q.push_back('{ep:8'd3, err:3'd0, conv:1'b1, tmo:1'b0, w0:16'h3800, w1:16'h3800, w2:16'h3800, gos:3});
    pulse_start();
    if (poke_start) begin
      repeat (4) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL poke_busy: got %b want 1", busy); end
      pulse_start();
    end
    wait_done(300, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL third_done(poke=%0d): got %b want 1", poke_start, done); end
    n_cmp++; if (epoch_cnt !== e.ep) begin n_err++; $display("[TB] FAIL third_epoch(poke=%0d): got %0d want %0d", poke_start, epoch_cnt, e.ep); end
    n_cmp++; if (err_cnt !== e.err) begin n_err++; $display("[TB] FAIL third_err(poke=%0d): got %0d want %0d", poke_start, err_cnt, e.err); end
    n_cmp++; if (converged !== e.conv) begin n_err++; $display("[TB] FAIL third_conv(poke=%0d): got %b want %b", poke_start, converged, e.conv); end
    n_cmp++; if ({ep_w0, ep_w1, ep_w2} !== {e.w0, e.w1, e.w2}) begin
      n_err++; $display("[TB] FAIL third_weights(poke=%0d): got %h want %h", poke_start, {ep_w0, ep_w1, ep_w2}, {e.w0, e.w1, e.w2});
    end
    n_cmp++; if (go_count !== e.gos) begin n_err++; $display("[TB] FAIL third_gos(poke=%0d): got %0d want %0d", poke_start, go_count, e.gos); end
  endtask

  task automatic test_max_ep(input logic [63:0] res, input logic [15:0] wn, input logic [2:0] want_err);
    exp_t e; bit ok;
    w_init0 = 16'h1111; w_init1 = 16'h2222; w_init2 = 16'h3333;
    set_stub(res, res, res, res, wn);
    sb_q.push_back('{ep:8'd4, err:want_err, conv:1'b0, tmo:1'b0, w0:wn, w1:wn, w2:wn, gos:4});
    pulse_start();
    wait_done(300, ok);
    e = sb_q.pop_front();
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL maxep_done: got %b want 1", done); end
    n_cmp++; if (epoch_cnt !== e.ep) begin n_err++; $display("[TB] FAIL maxep_epoch: got %0d want %0d", epoch_cnt, e.ep); end
    n_cmp++; if (err_cnt !== e.err) begin n_err++; $display("[TB] FAIL maxep_err: got %0d want %0d", err_cnt, e.err); end
    n_cmp++; if (converged !== e.conv) begin n_err++; $display("[TB] FAIL maxep_conv: got %b want %b", converged, e.conv); end
    n_cmp++; if ({ep_w0, ep_w1, ep_w2} !== {e.w0, e.w1, e.w2}) begin
      n_err++; $display("[TB] FAIL maxep_weights: got %h want %h", {ep_w0, ep_w1, ep_w2}, {e.w0, e.w1, e.w2});
    end
    n_cmp++; if (go_count !== e.gos) begin n_err++; $display("[TB] FAIL maxep_gos: got %0d want %0d", go_count, e.gos); end
    repeat (3) @(negedge clk);
    n_cmp++; if (epoch_cnt !== e.ep || done !== 1'b1) begin
      n_err++; $display("[TB] FAIL maxep_hold: epoch %0d done %b want %0d 1", epoch_cnt, done, e.ep);
    end
  endtask

  task automatic test_timeout();
    bit ok; int n;
    w_init0 = 16'h0101; w_init1 = 16'h0202; w_init2 = 16'h0303;
    set_stub(64'h0, 64'h0, 64'h0, 64'h0, 16'h7777);
    stub_silent = 1'b1;
`ifdef CONTROLE_TREINO_TIMEOUT_EN
    sb_q.push_back('{ep:8'd0, err:3'd0, conv:1'b0, tmo:1'b1, w0:16'h0101, w1:16'h0202, w2:16'h0303, gos:1});
`endif
    pulse_start();
    n = 0;
    while (ep_go !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (ep_go !== 1'b1) begin n_err++; $display("[TB] FAIL tmo_go: got %b want 1", ep_go); end
    @(negedge clk);
    n = 0;
`ifdef CONTROLE_TREINO_TIMEOUT_EN
    begin
      exp_t e;
      while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      e = sb_q.pop_front();
      n_cmp++; if (n !== 32) begin n_err++; $display("[TB] FAIL tmo_cycles: got %0d want 32", n); end
      n_cmp++; if (timeout !== e.tmo) begin n_err++; $display("[TB] FAIL tmo_flag: got %b want %b", timeout, e.tmo); end
      n_cmp++; if (converged !== e.conv) begin n_err++; $display("[TB] FAIL tmo_conv: got %b want %b", converged, e.conv); end
      n_cmp++; if ({ep_w0, ep_w1, ep_w2} !== {e.w0, e.w1, e.w2}) begin
        n_err++; $display("[TB] FAIL tmo_weights: got %h want %h", {ep_w0, ep_w1, ep_w2}, {e.w0, e.w1, e.w2});
      end
      n_cmp++; if (epoch_cnt !== e.ep) begin n_err++; $display("[TB] FAIL tmo_epoch: got %0d want %0d", epoch_cnt, e.ep); end
      ok = 1'b1;
    end
`else
    repeat (100) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL notmo_busy: got %b want 1", busy); end
    n_cmp++; if (done !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("[TB] FAIL notmo_flags: done %b timeout %b want 0 0", done, timeout);
    end
    ok = 1'b0;
`endif
    if (!ok) begin
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    w_init0 = 16'h4A00; w_init1 = 16'h4B00; w_init2 = 16'h4C00;
    set_stub(64'h0, 64'h0, 64'h0, 64'h0, 16'h6666);
    stub_silent = 1'b1;
    pulse_start();
    n = 0;
    while (ep_go !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    n_cmp++; if (ep_w0 !== 16'h4A00) begin n_err++; $display("[TB] FAIL rst_loaded: got %h want 4a00", ep_w0); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({busy, done, ep_go, converged, epoch_cnt, err_cnt} !== 15'd0) begin
      n_err++; $display("[TB] FAIL rst_async: got %b want 0", {busy, done, ep_go, converged, epoch_cnt, err_cnt});
    end
    n_cmp++; if ({ep_w0, ep_w1, ep_w2} !== 48'd0) begin
      n_err++; $display("[TB] FAIL rst_weights: got %h want 0", {ep_w0, ep_w1, ep_w2});
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    ep_done = 1'b1; ep_result = 64'h3C00_3C00_3C00_0000;
    ep_wn0 = 16'h6666; ep_wn1 = 16'h6666; ep_wn2 = 16'h6666;
    @(negedge clk); ep_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, converged, epoch_cnt} !== 11'd0) begin
      n_err++; $display("[TB] FAIL rst_late_done: got %b want 0", {busy, done, converged, epoch_cnt});
    end
    n_cmp++; if (ep_w0 !== 16'h0000) begin n_err++; $display("[TB] FAIL rst_no_update: got %h want 0", ep_w0); end
  endtask

  initial begin
    start = 1'b0; reset = 1'b0; ep_done = 1'b0; ep_result = '0;
    ep_wn0 = '0; ep_wn1 = '0; ep_wn2 = '0; d = '0;
    w_init0 = '0; w_init1 = '0; w_init2 = '0;
    stub_silent = 1'b1;
    for (int i = 0; i < 4; i++) stub_res[i] = '0;
    stub_wn0 = '0; stub_wn1 = '0; stub_wn2 = '0;

    test_reset();
    test_converge_first();
    test_neg_zero();
    test_converge_third(1'b0);
    test_converge_third(1'b1);
    test_max_ep(64'h3C00_0000_3C00_0000, 16'h4400, 3'd1);
    test_max_ep(64'h8000_BC00_0000_3C00, 16'hC000, 3'd4);
    test_timeout();
    test_reset_mid_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
